fetch_unit: RTL and testbench

FETCH_UNIT -- requirements
Module: fetch_unit

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_skid_buf.sv | 44 ++++
 rtl/fetch_unit.sv | 95 +++++++++
 tb/tb_fetch_unit.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit: FSM states, skid-buffer depth and the
// buffered fetch entry.
package fetch_pkg;

   localparam int FIFO_DEPTH = 2;
   localparam int CNT_W      = $clog2(FIFO_DEPTH + 1);

   typedef enum logic {
      RUN  = 1'b0,
      HALT = 1'b1
   } fetch_state_e;

   typedef struct packed {
      logic [31:0] word;
      logic [31:0] pc;
      logic        fault;
   } fetch_entry_t;

endpackage

// File: rtl/fetch_skid_buf.sv
// Two-entry FIFO between the code-memory return and decode. Flush wins over push/pop;
// head always shows the oldest entry (reset value is all zeros).
module fetch_skid_buf
   import fetch_pkg::*;
(
   input  logic             clk,
   input  logic             rst_n,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  fetch_entry_t     din,
   output logic [CNT_W-1:0] count,
   output fetch_entry_t     head
);

   fetch_entry_t mem [FIFO_DEPTH];
   logic         wr_ptr, rd_ptr;
   logic         do_pop;

   assign do_pop = pop && (count != '0);
   assign head   = mem[rd_ptr];

   // Depth is 2, so a single toggling bit serves as each pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < FIFO_DEPTH; i++) mem[i] <= '0;
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else if (flush) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= '0;
      end else begin
         if (push) begin
            mem[wr_ptr] <= din;
            wr_ptr      <= ~wr_ptr;
         end
         if (do_pop) rd_ptr <= ~rd_ptr;
         count <= count + CNT_W'(push) - CNT_W'(do_pop);
      end
   end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, one-cycle code memory, 2-entry skid buffer to decode.
// Optional FETCH_PERF_EN adds perf_fetch_count (accepted non-fault instructions).
module fetch_unit
   import fetch_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
   input  logic        clk,
   input  logic        rst_n,
   output logic [31:0] fetch_address,
   input  logic [31:0] code_fetch,
   input  logic        misaligned,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        instr_valid,
   input  logic        instr_ready,
   output logic [31:0] instr,
   output logic [31:0] instr_pc,
   output logic        instr_fault
`ifdef FETCH_PERF_EN
   ,
   output logic [31:0] perf_fetch_count
`endif
);

   fetch_state_e     state, state_nxt;
   logic [31:0]      pc, pc_nxt, inflight_pc;
   logic             inflight, issue, push, pop;
   logic [CNT_W-1:0] count;
   logic [CNT_W:0]   occ;
   fetch_entry_t     din, head;

   assign fetch_address = pc;
   assign pop           = instr_valid && instr_ready;
   // Slots committed after this cycle; never underflows since pop implies count >= 1.
   assign occ           = {1'b0, count} + (CNT_W+1)'(inflight) - (CNT_W+1)'(pop);

   always_comb begin
      state_nxt = state;
      pc_nxt    = pc;
      issue     = 1'b0;
      push      = 1'b0;
      if (redirect_valid) begin
         state_nxt = RUN;
         pc_nxt    = redirect_pc;
      end else begin
         issue = (state == RUN) && (occ < (CNT_W+1)'(FIFO_DEPTH));
         // Returns still in flight once a fault is queued are dropped, so the fault is
         // the last entry decode sees until the next redirect.
         push  = inflight && (state == RUN);
         if (issue) pc_nxt = pc + 32'd4;
         if (push && misaligned) state_nxt = HALT;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= RUN;
         pc          <= RESET_PC;
         inflight    <= 1'b0;
         inflight_pc <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         inflight <= issue;
         if (issue) inflight_pc <= pc;
      end
   end

   assign din = '{word: code_fetch, pc: inflight_pc, fault: misaligned};

   fetch_skid_buf u_skid (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push),
      .pop   (pop),
      .flush (redirect_valid),
      .din   (din),
      .count (count),
      .head  (head)
   );

   assign instr_valid = (count != '0);
   assign instr       = head.word;
   assign instr_pc    = head.pc;
   assign instr_fault = head.fault;

`ifdef FETCH_PERF_EN
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)                   perf_fetch_count <= '0;
      else if (pop && !instr_fault) perf_fetch_count <= perf_fetch_count + 32'd1;
   end
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Bench for fetch_unit: directed latency/stall/redirect/fault/reset cases, then random
// ready/redirect/reset traffic checked against an in-order instruction-stream model.
module tb_fetch_unit;

   localparam logic [31:0] RST_PC = 32'h0000_0000;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] fetch_address;
   logic [31:0] code_fetch = '0;
   logic        misaligned = 1'b0;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic [31:0] instr;
   logic [31:0] instr_pc;
   logic        instr_fault;
`ifdef FETCH_PERF_EN
   logic [31:0] perf_fetch_count;
   logic [31:0] exp_perf = '0;
`endif

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   fetch_unit #(.RESET_PC(RST_PC)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .fetch_address  (fetch_address),
      .code_fetch     (code_fetch),
      .misaligned     (misaligned),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .instr_valid    (instr_valid),
      .instr_ready    (instr_ready),
      .instr          (instr),
      .instr_pc       (instr_pc),
      .instr_fault    (instr_fault)
`ifdef FETCH_PERF_EN
      ,
      .perf_fetch_count (perf_fetch_count)
`endif
   );

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return (a * 32'h9E37_79B1) ^ 32'h0000_0013;
   endfunction

   // Code memory: one-cycle read latency, flags any address not word aligned.
   always @(posedge clk) begin
      code_fetch <= mem_word(fetch_address);
      misaligned <= |fetch_address[1:0];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h exp=%h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         #2;
      end
   endtask

   // Stream model: decode must see exp_pc, exp_pc+4, ... in order, ending after the
   // first misaligned address, restarting at each redirect target or reset.
   logic [31:0] exp_pc   = RST_PC;
   bit          exp_done = 1'b0;
   int          idle     = 0;

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_pc   = RST_PC;
         exp_done = 1'b0;
         idle     = 0;
`ifdef FETCH_PERF_EN
         exp_perf = '0;
`endif
      end else begin
`ifdef FETCH_PERF_EN
         chk("perf", perf_fetch_count, exp_perf);
         if (instr_valid && instr_ready && !instr_fault) exp_perf = exp_perf + 32'd1;
`endif
         if (redirect_valid) begin
            exp_pc   = redirect_pc;
            exp_done = 1'b0;
            idle     = 0;
         end else if (exp_done) begin
            chk("after_fault_valid", instr_valid, 1'b0);
         end else begin
            if (instr_valid) idle = 0;
            else             idle++;
            chk("live", idle > 3, 1'b0);
            if (instr_valid && instr_ready) begin
               chk("m_pc", instr_pc, exp_pc);
               chk("m_fault", instr_fault, |exp_pc[1:0]);
               if (|exp_pc[1:0]) exp_done = 1'b1;
               else              chk("m_word", instr, mem_word(exp_pc));
               exp_pc = exp_pc + 32'd4;
            end
         end
      end
   end

   logic [31:0] tgt;

   initial begin
      rst_n          = 1'b0;
      instr_ready    = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = '0;
      cyc(3);
      chk("rst_valid", instr_valid, 1'b0);
      chk("rst_instr", instr, 32'h0);
      chk("rst_pc", instr_pc, 32'h0);
      chk("rst_fault", instr_fault, 1'b0);
      chk("rst_addr", fetch_address, RST_PC);

      // Back-to-back stream after reset release, first valid in cycle 2
      rst_n = 1'b1; instr_ready = 1'b1;
      chk("c0_addr", fetch_address, RST_PC);
      cyc(1);
      chk("c1_valid", instr_valid, 1'b0);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("stream_valid", instr_valid, 1'b1);
         chk("stream_pc", instr_pc, RST_PC + 32'(4 * i));
      end

      // Decode stall: buffer fills, PC parks at 8, nothing lost
      rst_n = 1'b0;
      #1 chk("async_rst_valid", instr_valid, 1'b0);
      cyc(1);
      rst_n = 1'b1; instr_ready = 1'b0;
      cyc(2);
      chk("stall_first_valid", instr_valid, 1'b1);
      chk("stall_first_pc", instr_pc, RST_PC);
      for (int i = 0; i < 4; i++) begin
         cyc(1);
         chk("stall_addr", fetch_address, RST_PC + 32'd8);
         chk("stall_valid", instr_valid, 1'b1);
         chk("stall_head", instr_pc, RST_PC);
      end
      cyc(1);
      chk("rel_pc0", instr_pc, RST_PC);
      instr_ready = 1'b1;
      cyc(1);
      chk("rel_pc4", instr_pc, RST_PC + 32'd4);
      cyc(1);
      chk("rel_pc8", instr_pc, RST_PC + 32'd8);

      // Redirect with a full buffer
      instr_ready = 1'b0;
      cyc(3);
      chk("full_valid", instr_valid, 1'b1);
      redirect_valid = 1'b1; redirect_pc = 32'h40; instr_ready = 1'b1;
      cyc(1);
      redirect_valid = 1'b0;
      chk("redir_flush", instr_valid, 1'b0);
      chk("redir_addr", fetch_address, 32'h40);
      cyc(1);
      chk("redir_gap", instr_valid, 1'b0);
      cyc(1);
      chk("redir_valid", instr_valid, 1'b1);
      chk("redir_pc", instr_pc, 32'h40);
      chk("redir_word", instr, mem_word(32'h40));

      // Misaligned target: single fault entry, then fetch halts
      redirect_valid = 1'b1; redirect_pc = 32'h42;
      cyc(1);
      redirect_valid = 1'b0;
      cyc(2);
      chk("fault_valid", instr_valid, 1'b1);
      chk("fault_flag", instr_fault, 1'b1);
      chk("fault_pc", instr_pc, 32'h42);
      for (int i = 0; i < 5; i++) begin
         cyc(1);
         chk("halt_valid", instr_valid, 1'b0);
         chk("halt_addr", fetch_address, 32'h4A);
      end
      redirect_valid = 1'b1; redirect_pc = 32'h80;
      cyc(1);
      redirect_valid = 1'b0;
      cyc(2);
      chk("resume_valid", instr_valid, 1'b1);
      chk("resume_pc", instr_pc, 32'h80);
      chk("resume_fault", instr_fault, 1'b0);

      // Reset with a full buffer
      instr_ready = 1'b0;
      cyc(3);
      chk("pre_rst_valid", instr_valid, 1'b1);
      rst_n = 1'b0;
      #1;
      chk("mid_rst_valid", instr_valid, 1'b0);
      chk("mid_rst_pc", instr_pc, 32'h0);
      chk("mid_rst_fault", instr_fault, 1'b0);
      cyc(2);
      rst_n = 1'b1; instr_ready = 1'b1;
      cyc(2);
      chk("restart_valid", instr_valid, 1'b1);
      chk("restart_pc", instr_pc, RST_PC);

      // Random traffic
      for (int n = 0; n < 3000; n++) begin
         cyc(1);
         rst_n          = 1'b1;
         redirect_valid = 1'b0;
         instr_ready    = ($urandom_range(0, 3) != 0);
         if ($urandom_range(0, 399) == 0) begin
            rst_n = 1'b0;
         end else if ($urandom_range(0, 19) == 0) begin
            case ($urandom_range(0, 3))
               0:       tgt = $urandom & 32'hFFFF_FFFC;
               1:       tgt = 32'hFFFF_FFF0 + 32'(4 * $urandom_range(0, 3));
               2:       tgt = $urandom | 32'h1;
               default: tgt = 32'(4 * $urandom_range(0, 255));
            endcase
            redirect_valid = 1'b1;
            redirect_pc    = tgt;
         end
      end
      cyc(1);
      rst_n = 1'b1; redirect_valid = 1'b0; instr_ready = 1'b1;
      cyc(6);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
